lsu_mmio_pipe: RTL

//  Parametrised second-generation load/store unit: the data-memory and memory-mapped-IO port of the core.

---
 rtl/lsu_mmio_pipe_pkg.sv | 97 +++++++++
 rtl/lsu_mmio_pipe_if.sv | 25 ++
 rtl/lsu_mmio_pipe_dmem.sv | 36 +++
 rtl/lsu_mmio_pipe.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mmio_pipe_pkg.sv
// lsu_mmio_pipe_pkg
//   Shared types, address-map offsets and access helpers for the load/store unit.
//   - acc_size_e    : access width decoded from funct3
//   - ld_tag_e      : which source feeds the registered load return
//   - OFF_*         : byte offsets of the IO registers inside their blocks
//   - helper functions for size decode, alignment, byte enables, store-lane
//     replication, byte-enable merge and load lane-select/extension
package lsu_mmio_pipe_pkg;

  typedef enum logic [1:0] {
    ACC_B = 2'd0,
    ACC_H = 2'd1,
    ACC_W = 2'd2
  } acc_size_e;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DMEM = 2'd1,
    TAG_IO   = 2'd2
  } ld_tag_e;

  // Output block (relative to IO_BASE)
  localparam logic [31:0] OFF_LEDR   = 32'h0000_0000;
  localparam logic [31:0] OFF_LEDG   = 32'h0000_0010;
  localparam logic [31:0] OFF_HEX_LO = 32'h0000_0020;
  localparam logic [31:0] OFF_HEX_HI = 32'h0000_0024;
  localparam logic [31:0] OFF_LCD    = 32'h0000_0030;
  // Input block (relative to IN_BASE)
  localparam logic [31:0] OFF_SW     = 32'h0000_0000;
  localparam logic [31:0] OFF_BTN    = 32'h0000_0010;

  // Reserved encodings (011, 11x) fall through to a word access.
  function automatic acc_size_e decode_size(input logic [2:0] funct3);
    case (funct3)
      3'b000, 3'b100: return ACC_B;
      3'b001, 3'b101: return ACC_H;
      default:        return ACC_W;
    endcase
  endfunction

  function automatic logic is_unsigned(input logic [2:0] funct3);
    return (funct3 == 3'b100) || (funct3 == 3'b101);
  endfunction

  function automatic logic is_misaligned(input acc_size_e size, input logic [1:0] off);
    case (size)
      ACC_H:   return off[0];
      ACC_W:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input acc_size_e size, input logic [1:0] off);
    case (size)
      ACC_B:   return 4'b0001 << off;
      ACC_H:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data arrives LSB-aligned; copying it to every lane lets the byte
  // enables alone pick the destination lane.
  function automatic logic [31:0] replicate(input acc_size_e size, input logic [31:0] data);
    case (size)
      ACC_B:   return {4{data[7:0]}};
      ACC_H:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] apply_be(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  function automatic logic [31:0] load_extend(input acc_size_e   size,
                                              input logic        uns,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      ACC_B:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
      ACC_H:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mmio_pipe_if.sv
// lsu_mmio_pipe_if
//   Request/response bundle between the execute stage (master) and the
//   load/store unit (slave).
//   req, wren, funct3, addr, st_data : request, driven by master
//   ld_valid, ld_data, misaligned    : response, driven by slave
interface lsu_mmio_pipe_if;
  logic        req;
  logic        wren;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] st_data;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        misaligned;

  modport master (
    output req, wren, funct3, addr, st_data,
    input  ld_valid, ld_data, misaligned
  );

  modport slave (
    input  req, wren, funct3, addr, st_data,
    output ld_valid, ld_data, misaligned
  );
endinterface

// File: rtl/lsu_mmio_pipe_dmem.sv
// lsu_mmio_pipe_dmem
//   WORDS x 32 synchronous data RAM, one port, four byte-write enables and a
//   registered read (read-before-write on a same-cycle collision).
//   i_clk : clock
//   we    : write strobe, qualified per lane by be
//   be    : byte enables, lane n = bits [8n+7:8n]
//   addr  : word index
//   wdata : write data (lane-aligned)
//   rdata : registered read data of addr from the previous edge
//   Contents are deliberately not reset.
module lsu_mmio_pipe_dmem #(
  parameter  int WORDS = 2048,
  localparam int AW    = $clog2(WORDS)
) (
  input  logic          i_clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // One byte-wide array per lane maps cleanly onto byte-write block RAM.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [WORDS];
    logic [7:0] lane_q_reg;

    always_ff @(posedge i_clk) begin
      if (we && be[gi]) lane_mem[addr] <= wdata[8*gi +: 8];
      lane_q_reg <= lane_mem[addr];
    end

    assign rdata[8*gi +: 8] = lane_q_reg;
  end

endmodule

// File: rtl/lsu_mmio_pipe.sv
// lsu_mmio_pipe
//   Data-memory / memory-mapped-IO port of the core. One request per cycle,
//   stores commit at the request edge, loads return one cycle later.
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   bus (slave)       : req/wren/funct3/addr/st_data in, ld_valid/ld_data/misaligned out
//   o_io_ledr/ledg    : LED registers
//   o_io_hex          : NUM_HEX 7-segment displays, display k at [7k+6:7k]
//   o_io_lcd          : LCD register
//   i_io_sw, i_io_btn : asynchronous board inputs, synchronised SYNC_STAGES deep
module lsu_mmio_pipe
  import lsu_mmio_pipe_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE   = 32'h0000_2000,
  parameter int          DMEM_WORDS  = 2048,
  parameter logic [31:0] IO_BASE     = 32'h0000_7000,
  parameter logic [31:0] IN_BASE     = 32'h0000_7800,
  parameter int          NUM_HEX     = 8,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  lsu_mmio_pipe_if.slave         bus,
  output logic [31:0]            o_io_ledr,
  output logic [31:0]            o_io_ledg,
  output logic [7*NUM_HEX-1:0]   o_io_hex,
  output logic [31:0]            o_io_lcd,
  input  logic [31:0]            i_io_sw,
  input  logic [3:0]             i_io_btn
);

  localparam int          AW         = $clog2(DMEM_WORDS);
  localparam logic [31:0] DMEM_BYTES = 32'(4 * DMEM_WORDS);
  localparam logic [31:0] LEDR_ADDR   = IO_BASE + OFF_LEDR;
  localparam logic [31:0] LEDG_ADDR   = IO_BASE + OFF_LEDG;
  localparam logic [31:0] HEX_LO_ADDR = IO_BASE + OFF_HEX_LO;
  localparam logic [31:0] HEX_HI_ADDR = IO_BASE + OFF_HEX_HI;
  localparam logic [31:0] LCD_ADDR    = IO_BASE + OFF_LCD;
  localparam logic [31:0] SW_ADDR     = IN_BASE + OFF_SW;
  localparam logic [31:0] BTN_ADDR    = IN_BASE + OFF_BTN;

  // ---------------------------------------------------------------- decode
  acc_size_e   acc_size;
  logic        acc_uns;
  logic        mis;
  logic [3:0]  be;
  logic [31:0] st_word;
  logic [31:0] dmem_off;
  logic        dmem_hit;
  logic        hit_ledr, hit_ledg, hit_hex_lo, hit_hex_hi, hit_lcd, hit_sw, hit_btn;
  logic        io_hit;
  logic        st_ok;
  logic        is_load;

  assign acc_size = decode_size(bus.funct3);
  assign acc_uns  = is_unsigned(bus.funct3);
  assign mis      = is_misaligned(acc_size, bus.addr[1:0]);
  assign be       = byte_en(acc_size, bus.addr[1:0]);
  assign st_word  = replicate(acc_size, bus.st_data);

  // Offset compare handles both window edges with one subtraction.
  assign dmem_off = bus.addr - DMEM_BASE;
  assign dmem_hit = (bus.addr >= DMEM_BASE) && (dmem_off < DMEM_BYTES);

  // IO registers decode on the word address; the lane comes from be.
  assign hit_ledr   = bus.addr[31:2] == LEDR_ADDR[31:2];
  assign hit_ledg   = bus.addr[31:2] == LEDG_ADDR[31:2];
  assign hit_hex_lo = bus.addr[31:2] == HEX_LO_ADDR[31:2];
  assign hit_hex_hi = bus.addr[31:2] == HEX_HI_ADDR[31:2];
  assign hit_lcd    = bus.addr[31:2] == LCD_ADDR[31:2];
  assign hit_sw     = bus.addr[31:2] == SW_ADDR[31:2];
  assign hit_btn    = bus.addr[31:2] == BTN_ADDR[31:2];
  assign io_hit     = hit_ledr | hit_ledg | hit_hex_lo | hit_hex_hi | hit_lcd | hit_sw | hit_btn;

  // A misaligned access must leave every piece of state untouched.
  assign st_ok   = bus.req && bus.wren && !mis;
  assign is_load = bus.req && !bus.wren;

  // ---------------------------------------------------------- synchronisers
  logic [31:0] sw_sync_reg  [SYNC_STAGES];
  logic [3:0]  btn_sync_reg [SYNC_STAGES];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sw_sync_reg[i]  <= '0;
        btn_sync_reg[i] <= '0;
      end
    end else begin
      sw_sync_reg[0]  <= i_io_sw;
      btn_sync_reg[0] <= i_io_btn;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_sync_reg[i]  <= sw_sync_reg[i-1];
        btn_sync_reg[i] <= btn_sync_reg[i-1];
      end
    end
  end

  // ------------------------------------------------------ output registers
  logic [31:0] ledr_reg, ledg_reg, lcd_reg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ledr_reg <= '0;
      ledg_reg <= '0;
      lcd_reg  <= '0;
    end else if (st_ok) begin
      if (hit_ledr) ledr_reg <= apply_be(ledr_reg, st_word, be);
      if (hit_ledg) ledg_reg <= apply_be(ledg_reg, st_word, be);
      if (hit_lcd)  lcd_reg  <= apply_be(lcd_reg,  st_word, be);
    end
  end

  assign o_io_ledr = ledr_reg;
  assign o_io_ledg = ledg_reg;
  assign o_io_lcd  = lcd_reg;

  // Eight HEX lanes are always decoded; lanes beyond NUM_HEX have no storage
  // and read back as zero. Bit 7 of each lane is not stored.
  logic [7:0]  hex_rd [8];
  logic [31:0] hex_lo_word, hex_hi_word;

  for (genvar gi = 0; gi < 8; gi++) begin : g_hex
    if (gi < NUM_HEX) begin : g_on
      logic [6:0] seg_reg;
      logic       word_hit;

      assign word_hit = (gi < 4) ? hit_hex_lo : hit_hex_hi;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          seg_reg <= '0;
        end else if (st_ok && word_hit && be[gi % 4]) begin
          seg_reg <= st_word[8*(gi % 4) +: 7];
        end
      end

      assign hex_rd[gi]            = {1'b0, seg_reg};
      assign o_io_hex[7*gi +: 7]   = seg_reg;
    end else begin : g_off
      assign hex_rd[gi] = 8'h00;
    end
  end

  assign hex_lo_word = {hex_rd[3], hex_rd[2], hex_rd[1], hex_rd[0]};
  assign hex_hi_word = {hex_rd[7], hex_rd[6], hex_rd[5], hex_rd[4]};

  // ------------------------------------------------------- IO read mux
  logic [31:0] io_rdata;

  always_comb begin
    io_rdata = '0;
    if (hit_ledr)        io_rdata = ledr_reg;
    else if (hit_ledg)   io_rdata = ledg_reg;
    else if (hit_hex_lo) io_rdata = hex_lo_word;
    else if (hit_hex_hi) io_rdata = hex_hi_word;
    else if (hit_lcd)    io_rdata = lcd_reg;
    else if (hit_sw)     io_rdata = sw_sync_reg[SYNC_STAGES-1];
    else if (hit_btn)    io_rdata = {28'h0, btn_sync_reg[SYNC_STAGES-1]};
  end

  // ------------------------------------------------------------ data RAM
  logic [31:0] dmem_rdata;

  lsu_mmio_pipe_dmem #(
    .WORDS (DMEM_WORDS)
  ) u_dmem (
    .i_clk (i_clk),
    .we    (st_ok && dmem_hit),
    .be    (be),
    .addr  (dmem_off[AW+1:2]),
    .wdata (st_word),
    .rdata (dmem_rdata)
  );

  // ---------------------------------------------------------- load return
  // Both sources are captured at the request edge (RAM internally, IO into
  // io_rdata_reg); the registered tag picks one and the lane select plus
  // extension follow in the response cycle.
  logic        ld_valid_reg;
  logic        mis_reg;
  ld_tag_e     ld_tag_reg;
  acc_size_e   ld_size_reg;
  logic        ld_uns_reg;
  logic [1:0]  ld_off_reg;
  logic [31:0] io_rdata_reg;
  logic [31:0] ld_hold_reg;
  logic [31:0] ld_word;
  logic [31:0] ld_ext;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ld_valid_reg <= 1'b0;
      mis_reg      <= 1'b0;
      ld_tag_reg   <= TAG_NONE;
      ld_size_reg  <= ACC_W;
      ld_uns_reg   <= 1'b0;
      ld_off_reg   <= 2'b00;
      io_rdata_reg <= '0;
      ld_hold_reg  <= '0;
    end else begin
      ld_valid_reg <= is_load;
      mis_reg      <= bus.req && mis;
      // Keep the response visible once ld_valid drops.
      if (ld_valid_reg) ld_hold_reg <= ld_ext;
      if (is_load) begin
        ld_size_reg  <= acc_size;
        ld_uns_reg   <= acc_uns;
        ld_off_reg   <= bus.addr[1:0];
        io_rdata_reg <= io_rdata;
        if (mis)           ld_tag_reg <= TAG_NONE;
        else if (dmem_hit) ld_tag_reg <= TAG_DMEM;
        else if (io_hit)   ld_tag_reg <= TAG_IO;
        else               ld_tag_reg <= TAG_NONE;
      end
    end
  end

  always_comb begin
    ld_word = '0;
    case (ld_tag_reg)
      TAG_DMEM: ld_word = dmem_rdata;
      TAG_IO:   ld_word = io_rdata_reg;
      default:  ld_word = '0;
    endcase
  end

  assign ld_ext = load_extend(ld_size_reg, ld_uns_reg, ld_off_reg, ld_word);

  assign bus.ld_valid   = ld_valid_reg;
  assign bus.ld_data    = ld_valid_reg ? ld_ext : ld_hold_reg;
  assign bus.misaligned = mis_reg;

endmodule
